// File: rtl/seg_scan_decoder_pkg.sv
// seg_pkg: segment pattern table, FSM states and digit count for the scan decoder
package seg_pkg;
    localparam int DIGITS = 8;
    localparam logic [6:0] SEG_PAT [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b1100000, 7'b0001111,
        7'b0000000, 7'b0001100, 7'b1110010, 7'b1100110,
        7'b1011100, 7'b0110100, 7'b1110000, 7'b1111111
    };
    typedef enum logic [1:0] {IDLE, SETTLE, HOLD} state_e;
endpackage

// File: rtl/seg_pattern_decode.sv
// seg_pattern_decode: maps an active-low 7-segment pattern to {valid, nibble}
module seg_pattern_decode
    import seg_pkg::*;
(
    input  logic [6:0] pattern,
    output logic       valid,
    output logic [3:0] nibble
);
    always_comb begin
        valid = 1'b0;
        nibble = 4'd0;
        for (int i = 0; i < 16; i++)
            if (pattern == SEG_PAT[i]) begin
                valid = 1'b1;
                nibble = 4'(i);
            end
    end
endmodule

// File: rtl/seg_scan_decoder.sv
// seg_scan_decoder: recovers digit nibbles and decimal points from a multiplexed 7-segment scan bus
module seg_scan_decoder
    import seg_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [6:0]  seg_in,
    input  logic [7:0]  an_in,
    input  logic        dp_in,
    output logic [31:0] digits,
    output logic [7:0]  dp_out,
    output logic [7:0]  err_mask,
    output logic        frame_done,
    output logic [7:0]  frame_cnt
);
    localparam logic [7:0] SETTLE_N = 8'(SETTLE_CYCLES);
    logic [7:0] an_q;
    logic [6:0] seg_q;
    logic dp_q;
    state_e state_q, state_d;
    logic [15:0] lat_q, lat_d;
    logic [7:0] cnt_q, cnt_d, seen_q, seen_d, dp_out_q, dp_out_d, err_q, err_d, frame_cnt_q, frame_cnt_d;
    logic [31:0] digits_q, digits_d;
    logic frame_done_q, frame_done_d;
    logic [15:0] sample;
    logic one_hot, capture, valid;
    logic [3:0] nibble;
    logic [7:0] cap_mask;

    assign sample = {an_q, seg_q, dp_q};
    assign one_hot = $onehot(~an_q);

    seg_pattern_decode u_decode (
        .pattern(seg_q),
        .valid  (valid),
        .nibble (nibble)
    );

    always_comb begin
        state_d = state_q;
        lat_d = lat_q;
        cnt_d = cnt_q;
        if (state_q != IDLE && sample == lat_q)
            cnt_d = (state_q == SETTLE) ? cnt_q + 8'd1 : cnt_q;
        else if (one_hot) begin
            state_d = SETTLE;
            lat_d = sample;
            cnt_d = 8'd1;
        end else begin
            state_d = IDLE;
            cnt_d = 8'd0;
        end
        capture = state_d == SETTLE && cnt_d == SETTLE_N;
        if (capture)
            state_d = HOLD;
        cap_mask = capture ? ~an_q : 8'd0;
        frame_done_d = &seen_q;
        // a capture landing on the frame boundary starts the next frame
        seen_d = (frame_done_d ? 8'd0 : seen_q) | cap_mask;
        frame_cnt_d = frame_cnt_q + {7'd0, frame_done_d};
        digits_d = digits_q;
        dp_out_d = dp_out_q;
        err_d = err_q;
        for (int i = 0; i < DIGITS; i++)
            if (cap_mask[i]) begin
                if (valid)
                    digits_d[4*i +: 4] = nibble;
                dp_out_d[i] = ~dp_q;
                err_d[i] = ~valid;
            end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            an_q <= 8'hff;
            seg_q <= 7'h7f;
            dp_q <= 1'b1;
            state_q <= IDLE;
            lat_q <= '0;
            cnt_q <= '0;
            seen_q <= '0;
            digits_q <= '0;
            dp_out_q <= '0;
            err_q <= '0;
            frame_done_q <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            an_q <= an_in;
            seg_q <= seg_in;
            dp_q <= dp_in;
            state_q <= state_d;
            lat_q <= lat_d;
            cnt_q <= cnt_d;
            seen_q <= seen_d;
            digits_q <= digits_d;
            dp_out_q <= dp_out_d;
            err_q <= err_d;
            frame_done_q <= frame_done_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign digits = digits_q;
    assign dp_out = dp_out_q;
    assign err_mask = err_q;
    assign frame_done = frame_done_q;
    assign frame_cnt = frame_cnt_q;
endmodule

// File: tb/tb_seg_scan_decoder.sv
// tb_seg_scan_decoder: table vectors, corner sequences and random scans against a run-length model
module tb_seg_scan_decoder;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [6:0] seg_in = 7'h7f;
    logic [7:0] an_in = 8'hff;
    logic dp_in = 1'b1;
    logic [31:0] dig [2];
    logic [7:0] dpo [2];
    logic [7:0] err [2];
    logic [7:0] fcnt [2];
    logic fd [2];

    seg_scan_decoder #(.SETTLE_CYCLES(4)) dut4 (
        .clk(clk), .rst(rst), .seg_in(seg_in), .an_in(an_in), .dp_in(dp_in),
        .digits(dig[0]), .dp_out(dpo[0]), .err_mask(err[0]), .frame_done(fd[0]), .frame_cnt(fcnt[0])
    );
    seg_scan_decoder #(.SETTLE_CYCLES(1)) dut1 (
        .clk(clk), .rst(rst), .seg_in(seg_in), .an_in(an_in), .dp_in(dp_in),
        .digits(dig[1]), .dp_out(dpo[1]), .err_mask(err[1]), .frame_done(fd[1]), .frame_cnt(fcnt[1])
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [6:0] seg;
        logic [3:0] nib;
        logic       valid;
    } vec_t;
    typedef struct {
        logic [31:0] digits;
        logic [7:0]  dp, err, seen, fcnt;
        logic        fd;
        logic [15:0] prev;
        int          run;
    } mdl_t;

    vec_t tab [18];
    mdl_t m [2];
    logic [15:0] last_in;
    int total = 0;
    int bad = 0;
    int pulses [2];

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            if (bad <= 30)
                $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void mreset();
        for (int d = 0; d < 2; d++) begin
            m[d] = '{default: 0};
            m[d].prev = 16'hffff;
        end
        last_in = 16'hffff;
    endfunction

    // A digit is captured when the same one-hot sample has been seen exactly N times in a row.
    function automatic void mstep(input logic [15:0] s);
        logic [7:0] an;
        logic [6:0] seg;
        logic ok;
        logic [3:0] nib;
        an = s[15:8];
        seg = s[7:1];
        ok = 1'b0;
        nib = 4'd0;
        for (int p = 0; p < 18; p++)
            if (tab[p].valid && tab[p].seg == seg) begin
                ok = 1'b1;
                nib = tab[p].nib;
            end
        for (int d = 0; d < 2; d++) begin
            m[d].fd = m[d].seen == 8'hff;
            if (m[d].fd) begin
                m[d].seen = 8'd0;
                m[d].fcnt = m[d].fcnt + 8'd1;
            end
            m[d].run = (s == m[d].prev) ? m[d].run + 1 : 1;
            m[d].prev = s;
            if ($countones(~an) == 1 && m[d].run == (d == 0 ? 4 : 1))
                for (int k = 0; k < 8; k++)
                    if (!an[k]) begin
                        if (ok)
                            m[d].digits[4*k +: 4] = nib;
                        m[d].err[k] = ~ok;
                        m[d].dp[k] = ~s[0];
                        m[d].seen[k] = 1'b1;
                    end
        end
    endfunction

    task automatic cyc(input logic [7:0] an, input logic [6:0] seg, input logic dp, input int n);
        repeat (n) begin
            an_in = an;
            seg_in = seg;
            dp_in = dp;
            @(posedge clk);
            #1;
            mstep(last_in);
            last_in = {an, seg, dp};
            for (int d = 0; d < 2; d++) begin
                chk($sformatf("digits%0d", d), dig[d], m[d].digits);
                chk($sformatf("dp_out%0d", d), {24'd0, dpo[d]}, {24'd0, m[d].dp});
                chk($sformatf("err_mask%0d", d), {24'd0, err[d]}, {24'd0, m[d].err});
                chk($sformatf("frame_done%0d", d), {31'd0, fd[d]}, {31'd0, m[d].fd});
                chk($sformatf("frame_cnt%0d", d), {24'd0, fcnt[d]}, {24'd0, m[d].fcnt});
                if (fd[d])
                    pulses[d]++;
            end
        end
    endtask

    task automatic rst_pulse(input int n);
        an_in = 8'hff;
        seg_in = 7'h7f;
        dp_in = 1'b1;
        rst = 1'b1;
        repeat (n) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("rst_digits%0d", d), dig[d], 32'd0);
            chk($sformatf("rst_misc%0d", d), {dpo[d], err[d], fcnt[d], 7'd0, fd[d]}, 32'd0);
        end
        rst = 1'b0;
        mreset();
        pulses[0] = 0;
        pulses[1] = 0;
    endtask

    initial begin
        logic [7:0] an;
        logic [6:0] seg;
        logic dp;
        int k;
        tab = '{
            '{7'b0000001, 4'h0, 1'b1}, '{7'b1001111, 4'h1, 1'b1}, '{7'b0010010, 4'h2, 1'b1},
            '{7'b0000110, 4'h3, 1'b1}, '{7'b1001100, 4'h4, 1'b1}, '{7'b0100100, 4'h5, 1'b1},
            '{7'b1100000, 4'h6, 1'b1}, '{7'b0001111, 4'h7, 1'b1}, '{7'b0000000, 4'h8, 1'b1},
            '{7'b0001100, 4'h9, 1'b1}, '{7'b1110010, 4'ha, 1'b1}, '{7'b1100110, 4'hb, 1'b1},
            '{7'b1011100, 4'hc, 1'b1}, '{7'b0110100, 4'hd, 1'b1}, '{7'b1110000, 4'he, 1'b1},
            '{7'b1111111, 4'hf, 1'b1}, '{7'b1111110, 4'h0, 1'b0}, '{7'b0101010, 4'h0, 1'b0}
        };
        rst_pulse(3);
        for (int i = 0; i < 18; i++) begin
            k = i % 8;
            dp = 1'(i & 1);
            cyc(~(8'd1 << k), tab[i].seg, dp, 6);
            chk($sformatf("tab_nib%0d", i), {28'd0, dig[0][4*k +: 4]},
                {28'd0, tab[i].valid ? tab[i].nib : tab[i-8].nib});
            chk($sformatf("tab_err%0d", i), {31'd0, err[0][k]}, {31'd0, ~tab[i].valid});
            chk($sformatf("tab_dp%0d", i), {31'd0, dpo[0][k]}, {31'd0, ~dp});
        end
        rst_pulse(2);
        for (int i = 0; i < 8; i++)
            cyc(~(8'd1 << i), tab[i+1].seg, 1'b1, 6);
        cyc(8'hff, 7'h7f, 1'b1, 3);
        chk("scan_digits", dig[0], 32'h87654321);
        chk("scan_err", {24'd0, err[0]}, 32'd0);
        chk("scan_pulses", pulses[0], 1);
        chk("scan_fcnt", {24'd0, fcnt[0]}, 32'd1);
        cyc(8'b11110111, 7'b1111110, 1'b0, 5);
        cyc(8'hff, 7'h7f, 1'b1, 2);
        chk("bad_err3", {31'd0, err[0][3]}, 32'd1);
        chk("bad_nib3", {28'd0, dig[0][15:12]}, 32'd4);
        chk("bad_dp3", {31'd0, dpo[0][3]}, 32'd1);
        rst_pulse(2);
        cyc(8'b11111110, 7'b1111111, 1'b1, 3);
        cyc(8'hff, 7'h7f, 1'b1, 5);
        chk("short_settle", dig[0], 32'd0);
        cyc(8'b11111100, 7'b0000001, 1'b0, 20);
        cyc(8'hff, 7'h7f, 1'b1, 2);
        chk("multi_an_digits", dig[0], 32'd0);
        chk("multi_an_err", {24'd0, err[0]}, 32'd0);
        chk("multi_an_pulses", pulses[0], 0);
        rst_pulse(2);
        for (int p = 0; p < 2; p++)
            for (int i = 0; i < 8; i++)
                cyc(~(8'd1 << i), tab[i].seg, 1'b1, 1);
        cyc(8'hff, 7'h7f, 1'b1, 3);
        chk("overlap_pulses1", pulses[1], 2);
        chk("overlap_pulses4", pulses[0], 0);
        rst_pulse(2);
        cyc(8'b11011111, tab[5].seg, 1'b1, 2);
        rst_pulse(2);
        cyc(8'hff, 7'h7f, 1'b1, 10);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("rst_mid_digits%0d", d), dig[d], 32'd0);
            chk($sformatf("rst_mid_pulses%0d", d), pulses[d], 0);
            chk($sformatf("rst_mid_dp%0d", d), {24'd0, dpo[d]}, 32'd0);
        end
        rst_pulse(2);
        for (int f = 0; f < 256; f++)
            for (int i = 0; i < 8; i++)
                cyc(~(8'd1 << i), tab[$urandom_range(0, 15)].seg, 1'($urandom), 5);
        cyc(8'hff, 7'h7f, 1'b1, 3);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("wrap_pulses%0d", d), pulses[d], 256);
            chk($sformatf("wrap_fcnt%0d", d), {24'd0, fcnt[d]}, 32'd0);
        end
        rst_pulse(2);
        for (int i = 0; i < 800; i++) begin
            k = $urandom_range(0, 9);
            an = k < 8 ? ~(8'd1 << k) : (k == 8 ? 8'($urandom) : 8'hff);
            seg = $urandom_range(0, 3) != 0 ? tab[$urandom_range(0, 15)].seg : 7'($urandom);
            cyc(an, seg, 1'($urandom), $urandom_range(1, 7));
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/seg_scan_decoder.md
SEG_SCAN_DECODER -- requirements
Module: seg_scan_decoder

Interface
REQ-001 Parameter: SETTLE_CYCLES, default 4, the number of consecutive identical samples required before a digit is captured (legal range 1..255).
REQ-002 Port: clk  input  1  the only clock; all state updates on its rising edge.
REQ-003 Port: rst  input  1  asynchronous, active-high reset.
REQ-004 Port: seg_in  input  7  segment bus, active-low, seg_in[6]=a through seg_in[0]=g.
REQ-005 Port: an_in  input  8  digit enables, active-low, an_in[7] is the leftmost digit and an_in[0] the rightmost.
REQ-006 Port: dp_in  input  1  decimal point, active-low.
REQ-007 Port: digits  output  32  captured nibbles; digit k is held in bits [4k+3:4k].
REQ-008 Port: dp_out  output  8  captured decimal points, active-high, one bit per digit.
REQ-009 Port: err_mask  output  8  set where the last capture for that digit was a non-table pattern.
REQ-010 Port: frame_done  output  1  one-cycle pulse when all 8 positions have been captured since the previous pulse.
REQ-011 Port: frame_cnt  output  8  frame_done count, wrapping 255 -> 0.

Function
REQ-012 Inputs seg_in, an_in and dp_in shall be registered once before use, which adds 1 cycle of input latency.
REQ-013 An anode sample is "one-hot" when exactly one bit of an_in is 0.
REQ-014 The FSM shall have three states: IDLE, SETTLE and HOLD.
REQ-015 IDLE -> SETTLE on a one-hot sample; the current {an, seg, dp} is latched and the counter is loaded with 1.
REQ-016 In SETTLE, a sample identical to the latch increments the counter; any differing sample reloads the latch, resets the counter to 1 and stays in SETTLE if one-hot, else goes to IDLE.
REQ-017 When the counter reaches SETTLE_CYCLES, the FSM shall capture in that same cycle and go to HOLD.
REQ-018 In HOLD, any change of registered an_in shall leave HOLD: to SETTLE (with a fresh latch) if one-hot, else to IDLE.
REQ-019 In HOLD, a seg or dp change with unchanged an shall go to SETTLE, and the digit is captured again once it settles.
REQ-020 Capture of digit k shall write the decoded nibble, write dp_out[k] = ~dp, and set the seen bit k.
REQ-021 Capture shall set or clear err_mask[k] according to pattern validity; on an invalid pattern the nibble for digit k is left unchanged.
REQ-022 Decode table, pattern -> nibble:
  - 0000001->0, 1001111->1, 0010010->2, 0000110->3
  - 1001100->4, 0100100->5, 1100000->6, 0001111->7
  - 0000000->8, 0001100->9, 1110010->A, 1100110->B
  - 1011100->C, 0110100->D, 1110000->E, 1111111->F
REQ-023 When the seen mask becomes 8'hFF, frame_done shall pulse on the following cycle, the seen mask clears in that same cycle, and frame_cnt increments.
REQ-024 If a capture coincides with the seen-mask clear, the capture's seen bit shall survive the clear.
REQ-025 Zero anodes or multiple anodes active shall never capture, regardless of how long they persist.
REQ-026 When SETTLE_CYCLES=1, a digit shall be captured on the first registered one-hot sample.

Reset
REQ-027 While rst is high, all outputs shall be 0, the FSM in IDLE, the seen mask and counter at 0, and the input registers at all-ones (inactive).
REQ-028 A reset asserted mid-SETTLE or mid-HOLD shall discard the pending capture; no frame_done shall follow deassertion.

Structure
REQ-029 Package seg_pkg shall hold the 16 segment-pattern constants, the FSM state enum and DIGITS=8.
REQ-030 Combinational sub-module seg_pattern_decode shall map 7-bit pattern -> {valid, nibble[3:0]}.
REQ-031 Expected size is 150-250 lines of RTL.

Verification
REQ-032 Scan digits 0..7 showing patterns for 1,2,3,4,5,6,7,8, each held 6 cycles -> digits=32'h87654321, err_mask=0, one frame_done pulse, frame_cnt=1.
REQ-033 Hold an_in=8'b11111110 with seg=1111111 for 3 cycles then change, with SETTLE=4 -> no capture; digits[3:0] stays 0.
REQ-034 Drive an_in=8'b11111100 for 20 cycles -> no capture and no error.
REQ-035 Digit 3 with seg=1111110 and dp_in=0 for 5 cycles -> err_mask[3]=1, digits[15:12] unchanged, dp_out[3]=1.
REQ-036 Run 256 full frames -> frame_cnt wraps to 0 and 256 frame_done pulses are counted.
REQ-037 Assert rst after 2 cycles of settling on digit 5 -> all outputs 0, and no capture or frame_done occurs after release.
